// File: rtl/operand_entry.sv
// operand_entry: debounced load/clear buttons and synced switches sequence A, B, CarryIN into the adder.
// Latency: press event 2+DEBOUNCE_CYCLES cycles after a stable raw edge, registers update one cycle later.
// No backpressure (free-running user input); optional OPERAND_ENTRY_SUB_EN adds sub_mode for A-B entry.
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_load,
    input  logic       btn_clear,
`ifdef OPERAND_ENTRY_SUB_EN
    input  logic       sub_mode,
`endif
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       CarryIN,
    output logic       operands_valid,
    output logic       ready,
    output logic [1:0] state
);

    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_C    = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Button index 0 is load, index 1 is clear.
    logic [1:0]            btn_meta_q, btn_meta_d;
    logic [1:0]            btn_sync_q, btn_sync_d;
    logic [1:0]            acc_q, acc_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            evt_q, evt_d;

    logic [3:0] sw_meta_q, sw_meta_d;
    logic [3:0] sw_sync_q, sw_sync_d;

`ifdef OPERAND_ENTRY_SUB_EN
    logic sub_meta_q, sub_meta_d;
    logic sub_sync_q, sub_sync_d;
`endif

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       valid_q, valid_d;
    logic       ready_q, ready_d;

    logic load_evt;
    logic clear_evt;

    always_comb begin
        btn_meta_d = {btn_clear, btn_load};
        btn_sync_d = btn_meta_q;
        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
`ifdef OPERAND_ENTRY_SUB_EN
        sub_meta_d = sub_mode;
        sub_sync_d = sub_meta_q;
`endif
        acc_d = acc_q;
        cnt_d = '0;
        evt_d = '0;
        // A level change is accepted only after it persists; only the rising acceptance is an event.
        for (int i = 0; i < 2; i++) begin
            if (btn_sync_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    acc_d[i] = btn_sync_q[i];
                    evt_d[i] = btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign load_evt  = evt_q[0];
    assign clear_evt = evt_q[1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        valid_d = 1'b0;
        if (clear_evt) begin
            a_d     = 4'h0;
            b_d     = 4'h0;
            cin_d   = 1'b0;
            state_d = S_A;
        end else if (load_evt) begin
            case (state_q)
                S_A, S_DONE: begin
                    a_d     = sw_sync_q;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_sync_q;
                    state_d = S_C;
                end
                S_C: begin
                    cin_d = sw_sync_q[0];
`ifdef OPERAND_ENTRY_SUB_EN
                    // Two's complement of B turns the adder into a subtractor.
                    if (sub_sync_q) begin
                        b_d   = ~b_q;
                        cin_d = 1'b1;
                    end
`endif
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end
                default: state_d = S_A;
            endcase
        end
        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            evt_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
`ifdef OPERAND_ENTRY_SUB_EN
            sub_meta_q <= 1'b0;
            sub_sync_q <= 1'b0;
`endif
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            evt_q      <= evt_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
`ifdef OPERAND_ENTRY_SUB_EN
            sub_meta_q <= sub_meta_d;
            sub_sync_q <= sub_sync_d;
`endif
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    assign A              = a_q;
    assign B              = b_q;
    assign CarryIN        = cin_q;
    assign operands_valid = valid_q;
    assign ready          = ready_q;
    assign state          = state_q;

endmodule
